// File: rtl/dmem_arbiter.sv
// Round-robin arbiter: two load/store requesters share one async-read, sync-write data memory.
// Response 2 cycles after ready; one request per 2 cycles; ready only in IDLE, and valid may drop unaccepted.
module dmem_arbiter #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,

    input  logic                      i_req0_valid,
    output logic                      o_req0_ready,
    input  logic                      i_req0_we,
    input  logic [P_ADDR_WIDTH-1:0]   i_req0_addr,
    input  logic [P_DATA_WIDTH-1:0]   i_req0_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] i_req0_be,
    output logic                      o_rsp0_valid,
    output logic [P_DATA_WIDTH-1:0]   o_rsp0_rdata,

    input  logic                      i_req1_valid,
    output logic                      o_req1_ready,
    input  logic                      i_req1_we,
    input  logic [P_ADDR_WIDTH-1:0]   i_req1_addr,
    input  logic [P_DATA_WIDTH-1:0]   i_req1_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] i_req1_be,
    output logic                      o_rsp1_valid,
    output logic [P_DATA_WIDTH-1:0]   o_rsp1_rdata,

    output logic                      o_mem_we,
    output logic [P_ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [P_DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [P_DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int NB = P_DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]              state_q, state_d;
    logic                    last_q, last_d;
    logic                    we_q, we_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]           be_q, be_d;
    logic                    id_q, id_d;
    logic                    rsp0_vld_q, rsp0_vld_d;
    logic                    rsp1_vld_q, rsp1_vld_d;
    logic [P_DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [P_DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic                    gnt_id;
    logic                    ready0, ready1;
    logic                    mem_we;
    logic [P_ADDR_WIDTH-1:0] mem_addr;
    logic [P_DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        id_d         = id_q;
        rsp0_vld_d   = 1'b0;
        rsp1_vld_d   = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        gnt_id       = 1'b0;
        ready0       = 1'b0;
        ready1       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    // On a tie the requester not granted last time wins.
                    if (i_req0_valid && i_req1_valid)
                        gnt_id = ~last_q;
                    else
                        gnt_id = i_req1_valid;
                    ready0  = ~gnt_id;
                    ready1  = gnt_id;
                    we_d    = gnt_id ? i_req1_we    : i_req0_we;
                    addr_d  = gnt_id ? i_req1_addr  : i_req0_addr;
                    wdata_d = gnt_id ? i_req1_wdata : i_req0_wdata;
                    be_d    = gnt_id ? i_req1_be    : i_req0_be;
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr = addr_q;
                mem_we   = we_q && (be_q != '0);
                // Read-modify-write: unselected bytes are written back from the current word.
                for (int k = 0; k < NB; k++)
                    mem_wdata[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : i_mem_rdata[8*k +: 8];
                if (id_q) begin
                    rsp1_vld_d   = 1'b1;
                    rsp1_rdata_d = i_mem_rdata;
                end else begin
                    rsp0_vld_d   = 1'b1;
                    rsp0_rdata_d = i_mem_rdata;
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            id_q         <= 1'b0;
            rsp0_vld_q   <= 1'b0;
            rsp1_vld_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            id_q         <= id_d;
            rsp0_vld_q   <= rsp0_vld_d;
            rsp1_vld_q   <= rsp1_vld_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    // Reset masks handshakes and the write strobe immediately, aborting any access in flight.
    assign o_req0_ready = ready0 & ~i_rst;
    assign o_req1_ready = ready1 & ~i_rst;
    assign o_rsp0_valid = rsp0_vld_q & ~i_rst;
    assign o_rsp1_valid = rsp1_vld_q & ~i_rst;
    assign o_rsp0_rdata = rsp0_rdata_q;
    assign o_rsp1_rdata = rsp1_rdata_q;
    assign o_mem_we     = mem_we & ~i_rst;
    assign o_mem_addr   = mem_addr;
    assign o_mem_wdata  = mem_wdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 8: word-address width of the shared data memory.
REQ-002 SHALL have parameter P_DATA_WIDTH, default 32: data word width, a multiple of 8; NB = P_DATA_WIDTH/8.
REQ-003 SHALL use one clock, i_clk (rising edge), and reset i_rst, which is synchronous and active-high.
REQ-004 SHALL have the requester-0 ports:
- i_req0_valid  in  1  request valid
- o_req0_ready  out  1  request accepted
- i_req0_we  in  1  1=store, 0=load
- i_req0_addr  in  P_ADDR_WIDTH  word address
- i_req0_wdata  in  P_DATA_WIDTH  store data
- i_req0_be  in  NB  byte enables, bit k selects byte k
- o_rsp0_valid  out  1  one-cycle response pulse
- o_rsp0_rdata  out  P_DATA_WIDTH  word read at the address
REQ-005 SHALL have requester-1 ports identical to REQ-004 with prefix req1/rsp1.
REQ-006 SHALL have the memory-side ports:
- o_mem_we  out  1  write enable
- o_mem_addr  out  P_ADDR_WIDTH  address
- o_mem_wdata  out  P_DATA_WIDTH  write data
- i_mem_rdata  in  P_DATA_WIDTH  combinational read data
REQ-007 SHALL treat the memory as synchronous-write and asynchronous-read: i_mem_rdata reflects o_mem_addr in the same cycle.

Function
REQ-008 SHALL implement the FSM states IDLE and ACCESS.
REQ-009 In IDLE with at least one valid request, SHALL grant exactly one requester, assert its ready that cycle, latch we/addr/wdata/be/id, and move to ACCESS.
REQ-010 In IDLE with no valid request, SHALL hold all ready outputs at 0 and stay in IDLE.
REQ-011 Arbitration SHALL be round-robin:
- when one requester is valid, that requester wins;
- when both are valid, the requester not granted last wins;
- the last-grant register updates on each grant.
REQ-012 In ACCESS, SHALL drive o_mem_addr from the latched address, then return to IDLE on the next edge.
REQ-013 No ready SHALL assert in ACCESS, giving a maximum throughput of one request per 2 cycles.
REQ-014 In ACCESS, for a store with be != 0, SHALL assert o_mem_we and merge data bytewise: byte k = latched wdata byte k if be[k], else i_mem_rdata byte k (single-cycle read-modify-write).
REQ-015 In ACCESS, for a load or a store with be == 0, SHALL keep o_mem_we at 0.
REQ-016 At the edge leaving ACCESS, SHALL register i_mem_rdata (the pre-write word) into the granted requester's rsp_rdata.
REQ-017 SHALL pulse the granted requester's rsp_valid for exactly the one cycle after ACCESS, so response latency is 2 cycles after the ready cycle, for loads and stores alike.
REQ-018 The ungranted requester's rsp_valid SHALL stay 0, and its rsp_rdata SHALL hold its previous value.
REQ-019 A new grant MAY coincide with the rsp_valid cycle of the previous request (back-to-back operation).
REQ-020 When not in ACCESS, o_mem_addr and o_mem_wdata SHALL be 0 and o_mem_we SHALL be 0.
REQ-021 Requester address SHALL map directly to the memory address with no translation; the full range 0..2^P_ADDR_WIDTH-1 is legal, with no wrap or error.
REQ-022 The requester interface SHALL allow valid to be dropped without ready; an unaccepted request is simply not serviced.

Reset
REQ-023 While i_rst is high, SHALL force o_mem_we, o_req0_ready, o_req1_ready, o_rsp0_valid and o_rsp1_valid to 0 combinationally.
REQ-024 At a reset edge, SHALL set the state to IDLE, set last-grant to requester 1 (so requester 0 wins the first tie), and set both rsp_rdata to 0.
REQ-025 Reset asserted during ACCESS SHALL abort the access: no memory write occurs and no response is issued for the aborted request.

Verification
REQ-026 Single load: mem[0x10]=0xDEADBEEF; req0 load addr 0x10 -> ready0 at cycle 0, rsp0_valid at cycle 2 with rdata 0xDEADBEEF.
REQ-027 Partial store: mem[0x05]=0x11223344; req1 store wdata 0xAABBCCDD, be=0b0101 -> mem[0x05]=0x11BB33DD; rsp1 rdata 0x11223344.
REQ-028 Contention: both valid continuously after reset -> grants alternate 0,1,0,1 at cycles 0,2,4,6; each rsp goes only to the grantee.
REQ-029 Store with be=0 to addr 0xFF -> o_mem_we never asserts, mem unchanged, rsp valid with the old word.
REQ-030 Reset in ACCESS of a full store to 0x20 -> mem[0x20] unchanged, no rsp pulse, FSM in IDLE, next tie goes to requester 0.
